// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN result transmit path.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAY,
        CHK,
        END
    } tx_state_t;

    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
    localparam int         UART_BITS    = 10;

endpackage

// File: rtl/uart_tx_core.sv
// UART 8N1 byte serializer: start bit, d[0]..d[7], stop bit, each held BAUD_DIV clocks.
module uart_tx_core
    import cnn_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    output logic       bsy
);

    localparam int                  CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]       BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [3:0]          LAST_BIT  = 4'(UART_BITS - 1);

    logic [CW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [UART_BITS-1:0] shreg;
    logic                 baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign tx_done  = bsy && baud_end && (bit_cnt == LAST_BIT);
    // Line is forced high whenever idle so an async reset returns TX to 1 at once.
    assign TX       = bsy ? shreg[0] : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bsy      <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '1;
        end else if (!bsy) begin
            if (trmt) begin
                bsy      <= 1'b1;
                shreg    <= {1'b1, tx_data, 1'b0};
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end
        end else if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
                bsy     <= 1'b0;
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                shreg   <= {1'b1, shreg[UART_BITS-1:1]};
            end
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cnn_result_tx.sv
// Buffers cnn_core result bytes and sends them as [HDR, payload.., XOR checksum] UART packets.
module cnn_result_tx
    import cnn_pkg::*;
#(
    parameter int         BAUD_DIV   = 434,
    parameter int         FRAME_LEN  = 1,
    parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEF,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_vld,
    input  logic [7:0] res_data,
    output logic       res_rdy,
    output logic       TX,
    output logic       tx_bsy,
    output logic       frame_done,
    output logic       ovf
);

    localparam int               AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNTW       = AW + 1;
    localparam logic [CNTW-1:0]  FULL_CNT   = CNTW'(FIFO_DEPTH);
    localparam logic [3:0]       FRAME_LAST = 4'(FRAME_LEN);

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic            full, empty, push, pop;
    logic [7:0]      head;

    tx_state_t  state, state_nxt;
    logic [7:0] chk, chk_nxt;
    logic [3:0] pay_cnt, pay_cnt_nxt;
    logic       trmt, ser_done, ser_bsy;
    logic [7:0] tx_byte;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push    = res_vld && !full;
    assign head    = mem[rd_ptr];
    assign res_rdy = !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= res_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (res_vld && full) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            chk     <= '0;
            pay_cnt <= '0;
        end else begin
            state   <= state_nxt;
            chk     <= chk_nxt;
            pay_cnt <= pay_cnt_nxt;
        end
    end

    // Loads are only issued when the serializer is idle, which yields the one-clock inter-byte gap.
    always_comb begin
        state_nxt   = state;
        chk_nxt     = chk;
        pay_cnt_nxt = pay_cnt;
        pop         = 1'b0;
        trmt        = 1'b0;
        tx_byte     = HDR_BYTE;
        case (state)
            IDLE: begin
                if (!empty) begin
                    trmt        = 1'b1;
                    tx_byte     = HDR_BYTE;
                    chk_nxt     = '0;
                    pay_cnt_nxt = '0;
                    state_nxt   = HDR;
                end
            end
            HDR: begin
                if (ser_done) state_nxt = PAY;
            end
            PAY: begin
                if (ser_done && pay_cnt == FRAME_LAST) begin
                    state_nxt = CHK;
                end else if (!ser_bsy && !empty && pay_cnt != FRAME_LAST) begin
                    pop         = 1'b1;
                    trmt        = 1'b1;
                    tx_byte     = head;
                    chk_nxt     = chk ^ head;
                    pay_cnt_nxt = pay_cnt + 4'd1;
                end
            end
            CHK: begin
                if (ser_done) begin
                    state_nxt = END;
                end else if (!ser_bsy) begin
                    trmt    = 1'b1;
                    tx_byte = chk;
                end
            end
            END: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tx_bsy     = (state != IDLE);
    assign frame_done = (state == END);

    uart_tx_core #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart_tx_core (
        .clk     (clk),
        .rst     (rst),
        .trmt    (trmt),
        .tx_data (tx_byte),
        .TX      (TX),
        .tx_done (ser_done),
        .bsy     (ser_bsy)
    );

endmodule

// File: doc/cnn_result_tx.md
Name: cnn_result_tx

Overview:
- Output-side counterpart of the CNN UART input path. Accepts classification result bytes from cnn_core and frames them into packets. Serialises the packets on the TX pin as UART 8N1, LSB first.
- Sits between the cnn_core result handshake and the board TX pin.
- Pulses frame_done when a packet has fully left the pin, so the top level can re-arm the input RAM write/read pointers.

Parameters:
- BAUD_DIV, 434, clk cycles per UART bit (50 MHz / 115200); minimum 4.
- FRAME_LEN, 1, payload bytes per packet (1..15).
- HDR_BYTE, 8'hA5, packet header byte.
- FIFO_DEPTH, 4, result buffer entries (power of 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- res_vld  in  1  result byte valid from core (single-cycle strobe).
- res_data  in  8  result byte.
- res_rdy  out  1  FIFO not full.
- TX  out  1  UART serial output.
- tx_bsy  out  1  packet in progress (any state other than IDLE).
- frame_done  out  1  one-cycle pulse at end of packet.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (async, rst=1) state: TX=1, tx_bsy=0, frame_done=0, ovf=0, res_rdy=1, FIFO empty, FSM=IDLE, all counters 0. Reset mid-byte aborts immediately and TX returns to 1 that cycle.
- FIFO: push on res_vld && !full. If res_vld arrives while full, the byte is dropped and ovf is set to 1 until reset. Pop and push in the same cycle are both legal; the count is unchanged.
- Serializer timing:
  - A load starts the start bit (TX=0) on the next cycle.
  - Each bit is held exactly BAUD_DIV cycles. Order: start, d[0]..d[7], stop (1). One byte = 10*BAUD_DIV cycles.
  - The serializer returns byte_done for one cycle at the end of the stop bit.
- FSM states: IDLE, HDR, PAY, CHK, END.
  - IDLE: TX=1. When the FIFO is non-empty, load HDR_BYTE, clear chk to 0, clear pay_cnt, and go to HDR.
  - HDR: on byte_done, go to PAY.
  - PAY: when the serializer is idle and the FIFO is non-empty:
    - pop the FIFO, load the byte, set chk ^= byte, and increment pay_cnt;
    - TX stays 1 while waiting for data (mid-frame underflow is legal, with no timeout);
    - on the byte_done following the FRAME_LEN-th pop, load chk and go to CHK.
  - CHK: on byte_done, go to END.
  - END: frame_done=1 for exactly this one cycle, then go to IDLE.
- Inter-byte gap: exactly 1 idle-high clk between a byte's stop bit end and the next start bit, when data is available.
- Simultaneous events:
  - A res_vld push in the same cycle as a PAY pop from a 1-entry FIFO: the popped byte is the old head, and the new byte remains queued.
  - A byte arriving during HDR/CHK is only buffered.
- Width rules: pay_cnt is 4 bits and compares against FRAME_LEN. The baud counter is $clog2(BAUD_DIV) bits and wraps at BAUD_DIV-1. The bit counter is 4 bits, 0..9.
- tx_bsy is 1 from the cycle after leaving IDLE through END inclusive.

Decomposition:
- Package cnn_pkg:
  - typedef enum for the FSM states {IDLE, HDR, PAY, CHK, END};
  - localparam HDR_BYTE default;
  - localparam UART_BITS = 10.
- Sub-module uart_tx_core contains:
  - ports: clk, rst, trmt, tx_data[7:0], TX, tx_done, bsy;
  - the baud counter, bit counter and shift register.
- The FIFO and framing FSM live in cnn_result_tx.

Test Plan:
- Reset idle: rst=1 for 3 cycles, then 0, with no res_vld → TX=1, tx_bsy=0, res_rdy=1 for 100 cycles.
- Single packet: BAUD_DIV=4, FRAME_LEN=1, res_data=8'h07 strobe → TX carries bytes A5, 07, 07, each 40 cycles with a 1-cycle gap; frame_done pulses once, 1 cycle after the final stop bit.
- Multi-byte checksum: FRAME_LEN=2, push 8'h03 then 8'h05 → TX carries A5, 03, 05, 06; tx_bsy stays high throughout.
- Overflow and underflow:
  - overflow: FRAME_LEN=2, push 6 bytes back-to-back while HDR is being sent → res_rdy drops after the 4th byte; ovf=1; the 5th and 6th bytes are dropped;
  - underflow: FRAME_LEN=2, push only 1 byte → TX holds 1 after the first payload byte until a second byte is pushed, then resumes.
- Mid-byte reset: assert rst during bit 4 of the header → TX=1 in the same cycle; tx_bsy=0, ovf=0; a subsequent push starts a fresh A5 header.
